// File: rtl/pcpwm_multi.sv
// Multi-channel phase-correct PWM. All channels share one counter that runs
// either up/down (center-aligned) or as a sawtooth (edge-aligned). Channel
// magnitude and direction are double-buffered and applied at period start,
// a one-clock trigger marks each period start, and a watchdog clears the
// holding registers when the bus stops writing.
module pcpwm_multi #(
    parameter int unsigned NCH    = 4,
    parameter int unsigned CNT_W  = 11,
    parameter int unsigned DUTY_W = 8,
    parameter int unsigned WDT_W  = 24,
    parameter bit          CENTER = 1'b1,
    parameter int unsigned AW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     wsel,
    input  logic [DUTY_W:0]   wdata,
    input  logic              mode_we,
    input  logic              mode_in,
    input  logic [AW-1:0]     rsel,
    output logic [DUTY_W:0]   rdata,
    output logic              mode_act,
    output logic [NCH-1:0]    pwm,
    output logic [NCH-1:0]    dir,
    output logic              trig,
    output logic              wdt_to
);

    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [AW:0]      NchL   = (AW+1)'(NCH);

    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        up_q, up_d;
    logic                        mode_act_q, mode_pend_q;
    logic                        mode_nxt;
    logic                        pstart;
    logic [NCH-1:0][DUTY_W:0]    hold_q;
    logic [NCH-1:0][DUTY_W:0]    shadow_q;
    logic [NCH-1:0]              pwm_q, pwm_d;
    logic [NCH-1:0]              dir_q, dir_d;
    logic                        trig_q;
    logic [WDT_W-1:0]            wdt_q;
    logic                        wdt_to_q;
    logic                        wdt_fire;
    logic                        wr_accept;

    // Period start: the single cycle where the counter sits at 0 heading up.
    always_comb begin
        pstart = 1'b0;
        if (mode_act_q) begin
            pstart = (cnt_q == '0) && !up_q;
        end else begin
            pstart = (cnt_q == '0);
        end
        // A pending mode change takes effect at period start, so the counter
        // step taken in that cycle already follows the new mode.
        mode_nxt = pstart ? mode_pend_q : mode_act_q;
    end

    // Counter next state: up/down with 2-clk dwell at each extreme, or sawtooth.
    always_comb begin
        cnt_d = cnt_q;
        up_d  = up_q;
        if (mode_nxt) begin
            if (!up_q) begin
                if (cnt_q == '0) begin
                    up_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else begin
                if (cnt_q == CntMax) begin
                    up_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            up_d  = 1'b0;
        end
    end

    // Counter, direction flag and mode registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            up_q        <= 1'b0;
            mode_act_q  <= CENTER;
            mode_pend_q <= CENTER;
        end else begin
            cnt_q      <= cnt_d;
            up_q       <= up_d;
            mode_act_q <= mode_nxt;
            if (mode_we) begin
                mode_pend_q <= mode_in;
            end
        end
    end

    // Watchdog fires on its MSB; the clear takes priority over any bus write.
    always_comb begin
        wdt_fire  = wdt_q[WDT_W-1];
        wr_accept = we && !wdt_fire && ({1'b0, wsel} < NchL);
    end

    // Watchdog counter and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wdt_q    <= '0;
            wdt_to_q <= 1'b0;
        end else if (wdt_fire) begin
            wdt_q    <= '0;
            wdt_to_q <= 1'b1;
        end else begin
            if (we || mode_we) begin
                wdt_q <= '0;
            end else begin
                wdt_q <= wdt_q + WDT_W'(1);
            end
            if (wr_accept) begin
                wdt_to_q <= 1'b0;
            end
        end
    end

    // Holding registers: bus-visible, cleared by the watchdog.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else if (wdt_fire) begin
            hold_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_accept && (wsel == AW'(i))) begin
                    hold_q[i] <= wdata;
                end
            end
        end
    end

    // Shadow registers: loaded from holding only at period start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else if (pstart) begin
            shadow_q <= hold_q;
        end
    end

    // Per-channel compare; an all-ones magnitude forces a constant high.
    always_comb begin
        pwm_d = '0;
        dir_d = '0;
        for (int i = 0; i < NCH; i++) begin
            pwm_d[i] = (cnt_q[CNT_W-1 -: DUTY_W] < shadow_q[i][DUTY_W-1:0]) |
                       (&shadow_q[i][DUTY_W-1:0]);
            dir_d[i] = shadow_q[i][DUTY_W];
        end
    end

    // Registered pin outputs and the period-start trigger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_q  <= '0;
            dir_q  <= '0;
            trig_q <= 1'b0;
        end else begin
            pwm_q  <= pwm_d;
            dir_q  <= dir_d;
            trig_q <= pstart;
        end
    end

    // Readback mux; out-of-range selects read as zero.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (rsel == AW'(i)) begin
                rdata = hold_q[i];
            end
        end
    end

    assign mode_act = mode_act_q;
    assign pwm      = pwm_q;
    assign dir      = dir_q;
    assign trig     = trig_q;
    assign wdt_to   = wdt_to_q;

endmodule

// File: tb/tb_pcpwm_multi.sv
// Testbench for pcpwm_multi: a phase-indexed reference model predicts every
// cycle's outputs into a queue that a negedge monitor checks, while directed
// sections measure period/duty against fixed expected values.
module tb_pcpwm_multi;

    localparam int unsigned NCH    = 5;
    localparam int unsigned CNT_W  = 11;
    localparam int unsigned DUTY_W = 8;
    localparam int unsigned WDT_W  = 8;
    localparam int unsigned AW     = 3;
    localparam int unsigned MAXC   = (1 << CNT_W) - 1;
    localparam int unsigned MAGMAX = (1 << DUTY_W) - 1;
    localparam int unsigned WDT_TO = 1 << (WDT_W - 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              we = 1'b0;
    logic [AW-1:0]     wsel = '0;
    logic [DUTY_W:0]   wdata = '0;
    logic              mode_we = 1'b0;
    logic              mode_in = 1'b0;
    logic [AW-1:0]     rsel = '0;
    logic [DUTY_W:0]   rdata;
    logic              mode_act;
    logic [NCH-1:0]    pwm;
    logic [NCH-1:0]    dir;
    logic              trig;
    logic              wdt_to;

    pcpwm_multi #(
        .NCH    (NCH),
        .CNT_W  (CNT_W),
        .DUTY_W (DUTY_W),
        .WDT_W  (WDT_W),
        .CENTER (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .wsel     (wsel),
        .wdata    (wdata),
        .mode_we  (mode_we),
        .mode_in  (mode_in),
        .rsel     (rsel),
        .rdata    (rdata),
        .mode_act (mode_act),
        .pwm      (pwm),
        .dir      (dir),
        .trig     (trig),
        .wdt_to   (wdt_to)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [NCH-1:0]           pwm;
        logic [NCH-1:0]           dir;
        logic                     trig;
        logic                     mode;
        logic                     wto;
        logic [NCH-1:0][DUTY_W:0] hold;
    } exp_t;

    exp_t exp_q[$];

    // Counter value at a given position within the period.
    function automatic int unsigned cnt_of(int unsigned p, bit center);
        if (!center) return p;
        if (p <= MAXC + 1) return (p == 0) ? 0 : p - 1;
        return 2 * MAXC + 2 - p;
    endfunction

    function automatic int unsigned period_of(bit center);
        return center ? 2 * (MAXC + 1) : MAXC + 1;
    endfunction

    // Reference model: position in period, mode, buffers, watchdog.
    int unsigned               m_p;
    bit                        m_mode, m_pend, m_wto, m_trig;
    int unsigned               m_wdt;
    logic [NCH-1:0][DUTY_W:0]  m_hold, m_sh;
    logic [NCH-1:0]            m_pwm, m_dir;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_p = 0; m_mode = 1'b1; m_pend = 1'b1; m_wto = 1'b0; m_trig = 1'b0;
                m_wdt = 0; m_hold = '0; m_sh = '0; m_pwm = '0; m_dir = '0;
                exp_q.delete();
            end else begin
                int unsigned c;
                bit ps;
                exp_t e;
                c  = cnt_of(m_p, m_mode);
                ps = (m_p == 0);
                for (int i = 0; i < NCH; i++) begin
                    int unsigned mag;
                    mag      = int'(m_sh[i][DUTY_W-1:0]);
                    m_pwm[i] = ((c >> (CNT_W - DUTY_W)) < mag) || (mag == MAGMAX);
                    m_dir[i] = m_sh[i][DUTY_W];
                end
                m_trig = ps;
                if (ps) begin
                    m_sh   = m_hold;
                    m_mode = m_pend;
                end
                m_p = (m_p + 1) % period_of(m_mode);
                if (mode_we) m_pend = mode_in;
                if (m_wdt >= WDT_TO) begin
                    m_hold = '0;
                    m_wto  = 1'b1;
                    m_wdt  = 0;
                end else begin
                    if (we && (int'(wsel) < NCH)) begin
                        m_hold[int'(wsel)] = wdata;
                        m_wto = 1'b0;
                    end
                    m_wdt = (we || mode_we) ? 0 : m_wdt + 1;
                end
                e.pwm = m_pwm; e.dir = m_dir; e.trig = m_trig; e.mode = m_mode;
                e.wto = m_wto; e.hold = m_hold;
                exp_q.push_back(e);
            end
        end
    end

    // Monitor: every clock the DUT presents a new output set; compare it.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && exp_q.size() > 0) begin
                exp_t e;
                logic [DUTY_W:0] er;
                e  = exp_q.pop_front();
                er = (int'(rsel) < NCH) ? e.hold[int'(rsel)] : '0;
                n_checks++;
                if ({pwm, dir, trig, mode_act, wdt_to, rdata} !==
                    {e.pwm, e.dir, e.trig, e.mode, e.wto, er}) begin
                    n_fail++;
                    $display("FAIL cycle t=%0t pwm=%b exp %b dir=%b exp %b trig=%b exp %b mode=%b exp %b wdt_to=%b exp %b rdata=%h exp %h",
                             $time, pwm, e.pwm, dir, e.dir, trig, e.trig, mode_act, e.mode,
                             wdt_to, e.wto, rdata, er);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    bit pet_en  = 1'b0;
    int pet_ctr = 0;

    // Idle drive; optionally pets the watchdog via an out-of-range write.
    task automatic idle_drive();
        we      = 1'b0;
        mode_we = 1'b0;
        if (pet_en) begin
            pet_ctr++;
            if (pet_ctr >= 48) begin
                pet_ctr = 0;
                we      = 1'b1;
                wsel    = AW'($urandom_range(NCH, 7));
                wdata   = (DUTY_W+1)'($urandom);
            end
        end
    endtask

    // All stimulus tasks start and end at a negedge sample point.
    task automatic cyc();
        #1 idle_drive();
        @(negedge clk);
    endtask

    task automatic cyc_rsel(input int r);
        #1 idle_drive();
        rsel = AW'(r);
        @(negedge clk);
    endtask

    task automatic wr(input int ch, input int data);
        #1;
        we = 1'b1; mode_we = 1'b0;
        wsel = AW'(ch); wdata = (DUTY_W+1)'(data);
        @(negedge clk);
    endtask

    task automatic mode_wr(input bit m);
        #1;
        we = 1'b0; mode_we = 1'b1; mode_in = m;
        @(negedge clk);
    endtask

    int per_cnt;
    int hi_cnt [NCH];

    // Wait for trig, then count cycles and pwm-high cycles up to the next trig.
    task automatic measure();
        bit got;
        got = trig;
        for (int k = 0; k < 10000 && !got; k++) begin
            cyc();
            got = trig;
        end
        chk("trig_wait", int'(got), 1);
        per_cnt = 0;
        for (int i = 0; i < NCH; i++) hi_cnt[i] = 0;
        if (got) begin
            for (int k = 0; k < 10000; k++) begin
                for (int i = 0; i < NCH; i++) hi_cnt[i] += int'(pwm[i]);
                per_cnt++;
                cyc();
                if (trig) break;
            end
        end
    endtask

    initial begin
        int quiet;
        repeat (3) @(negedge clk);
        chk("reset_pwm", int'(pwm), 0);
        chk("reset_dir", int'(dir), 0);
        chk("reset_trig", int'(trig), 0);
        chk("reset_wdt_to", int'(wdt_to), 0);
        chk("reset_mode", int'(mode_act), 1);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("first_trig", int'(trig), 1);
        pet_en = 1'b1;

        // Center duty, direction, extremes.
        wr(0, 'h080);
        wr(1, 'h140);
        wr(2, 'h0FF);
        wr(3, 'h000);
        wr(4, 'h1A5);
        measure();
        measure();
        chk("center_period", per_cnt, 4096);
        chk("center_hi0", hi_cnt[0], 2048);
        chk("center_hi1", hi_cnt[1], 1024);
        chk("center_hi2_full", hi_cnt[2], 4096);
        chk("center_hi3_zero", hi_cnt[3], 0);
        chk("center_hi4", hi_cnt[4], 2640);
        chk("dir1", int'(dir[1]), 1);
        chk("dir3", int'(dir[3]), 0);

        // Double buffering.
        repeat (1000) cyc();
        wr(0, 'h040);
        chk("readback_next_clk", int'(rdata), 'h040);
        measure();
        chk("dbuf_hi0", hi_cnt[0], 1024);

        // Mode switch to edge.
        repeat (500) cyc();
        mode_wr(1'b0);
        chk("mode_held", int'(mode_act), 1);
        measure();
        chk("mode_switched", int'(mode_act), 0);
        chk("edge_period", per_cnt, 2048);
        chk("edge_hi0", hi_cnt[0], 512);
        chk("edge_hi2_full", hi_cnt[2], 2048);

        // Watchdog timeout.
        pet_en = 1'b0;
        repeat (140) cyc();
        chk("wdt_to_set", int'(wdt_to), 1);
        chk("wdt_hold_cleared", int'(rdata), 0);
        measure();
        measure();
        for (int i = 0; i < NCH; i++) chk("wdt_pwm_off", hi_cnt[i], 0);
        wr(0, 'h080);
        chk("wdt_to_cleared", int'(wdt_to), 0);
        repeat (WDT_TO) cyc();
        chk("pre_timeout_hold", int'(rdata), 'h080);
        wr(1, 'h0AA);
        chk("timeout_hold0", int'(rdata), 0);
        chk("timeout_wdt_to", int'(wdt_to), 1);
        cyc_rsel(1);
        chk("lost_write", int'(rdata), 0);
        cyc_rsel(0);

        // Async reset mid-period with live outputs.
        pet_en = 1'b1;
        wr(2, 'h1FF);
        measure();
        measure();
        pet_en = 1'b0;
        repeat (140) cyc();
        chk("pre_reset_pwm2", int'(pwm[2]), 1);
        chk("pre_reset_dir2", int'(dir[2]), 1);
        chk("pre_reset_wdt_to", int'(wdt_to), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_pwm", int'(pwm), 0);
        chk("async_dir", int'(dir), 0);
        chk("async_trig", int'(trig), 0);
        chk("async_wdt_to", int'(wdt_to), 0);
        chk("async_mode", int'(mode_act), 1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("release_trig", int'(trig), 1);
        cyc();
        chk("release_trig_width", int'(trig), 0);
        wr(5, 'h1FF);
        cyc_rsel(5);
        chk("oob_read", int'(rdata), 0);
        for (int r = 0; r < NCH; r++) begin
            cyc_rsel(r);
            chk("oob_write_ignored", int'(rdata), 0);
        end

        // Randomized traffic against the reference model.
        quiet = 0;
        for (int k = 0; k < 12000; k++) begin
            #1;
            we      = ($urandom_range(0, 15) == 0);
            wsel    = AW'($urandom_range(0, 7));
            wdata   = (DUTY_W+1)'($urandom);
            if ($urandom_range(0, 7) == 0) wdata[DUTY_W-1:0] = '1;
            if ($urandom_range(0, 7) == 0) wdata[DUTY_W-1:0] = '0;
            mode_we = ($urandom_range(0, 255) == 0);
            mode_in = 1'($urandom_range(0, 1));
            rsel    = AW'($urandom_range(0, 7));
            if (quiet > 0) begin
                we = 1'b0; mode_we = 1'b0; quiet--;
            end else if ($urandom_range(0, 1500) == 0) begin
                quiet = $urandom_range(100, 300);
            end
            @(negedge clk);
        end
        repeat (4) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
